// File: rtl/gray_counter_param.sv
// Generic-width up/down loadable Gray-code counter with a registered binary mirror and wrap flag.
// Define GRAY_CNT_SATURATE_EN to saturate at the limits; wrap then flags refused steps.
module gray_counter_param #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_BIN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ResetBin  = WIDTH'(RESET_BIN);
  localparam logic [WIDTH-1:0] ResetGray = ResetBin ^ (ResetBin >> 1);
  localparam logic [WIDTH-1:0] MaxBin    = {WIDTH{1'b1}};

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] step_bin;
  logic             at_limit;

  // A step at the limit in the current direction is the terminal event.
  assign at_limit = up_dn ? (bin_q == MaxBin) : (bin_q == '0);
  assign step_bin = up_dn ? (bin_q + 1'b1) : (bin_q - 1'b1);

  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d  = gray_to_bin(load_gray);
      gray_d = load_gray;
    end else if (en) begin
`ifdef GRAY_CNT_SATURATE_EN
      if (at_limit) begin
        wrap_d = 1'b1;
      end else begin
        bin_d  = step_bin;
        gray_d = bin_to_gray(step_bin);
      end
`else
      bin_d  = step_bin;
      gray_d = bin_to_gray(step_bin);
      wrap_d = at_limit;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= ResetBin;
      gray_q <= ResetGray;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray = gray_q;
  assign bin  = bin_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboarded directed bench for gray_counter_param (WIDTH=4, RESET_BIN 0 and 5 instances).
// Expectations follow GRAY_CNT_SATURATE_EN when the bench is built with it.
module tb_gray_counter_param;

  logic       clk = 1'b0;
  logic       rst, en, up_dn, load;
  logic [3:0] load_gray;
  logic [3:0] gray0, bin0, gray5, bin5;
  logic       wrap0, wrap5;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(4), .RESET_BIN(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .gray(gray0), .bin(bin0), .wrap(wrap0)
  );

  gray_counter_param #(.WIDTH(4), .RESET_BIN(5)) dut5 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .gray(gray5), .bin(bin5), .wrap(wrap5)
  );

  typedef struct packed {
    logic [3:0] g0;
    logic [3:0] b0;
    logic       w0;
    logic [3:0] g5;
    logic [3:0] b5;
    logic       w5;
    logic       stepped0;
    logic       loaded0;
  } exp_t;

  exp_t sb[$];

  int m_bin0 = 0;
  int m_bin5 = 5;

`ifdef GRAY_CNT_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  // Parity of all Gray bits at or above position i gives binary bit i.
  function automatic int model_g2b(input logic [3:0] g);
    logic [3:0] b;
    logic [3:0] sh;
    for (int i = 0; i < 4; i++) begin
      sh   = g >> i;
      b[i] = ^sh;
    end
    return int'(b);
  endfunction

  function automatic logic [3:0] model_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ {1'b0, v[3:1]};
  endfunction

  task automatic model_step(input int rb, input int cur, output int nxt, output logic w,
                            output logic stepped);
    w = 1'b0;
    stepped = 1'b0;
    nxt = cur;
    if (rst) nxt = rb;
    else if (load) nxt = model_g2b(load_gray);
    else if (en) begin
      if (up_dn && cur == 15) begin
        w = 1'b1;
        if (!Sat) begin nxt = 0; stepped = 1'b1; end
      end else if (!up_dn && cur == 0) begin
        w = 1'b1;
        if (!Sat) begin nxt = 15; stepped = 1'b1; end
      end else begin
        nxt = up_dn ? cur + 1 : cur - 1;
        stepped = 1'b1;
      end
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's prediction, then pop and compare after the edge.
  task automatic drive(input logic r, input logic l, input logic [3:0] lg, input logic e,
                       input logic u);
    exp_t x;
    exp_t got;
    int n0, n5;
    logic w0, w5, s0, s5;
    logic [3:0] prev_gray;
    @(negedge clk);
    rst = r; load = l; load_gray = lg; en = e; up_dn = u;
    model_step(0, m_bin0, n0, w0, s0);
    model_step(5, m_bin5, n5, w5, s5);
    m_bin0 = n0;
    m_bin5 = n5;
    x.g0 = model_gray(n0); x.b0 = 4'(n0); x.w0 = w0;
    x.g5 = model_gray(n5); x.b5 = 4'(n5); x.w5 = w5;
    x.stepped0 = s0 && !r;
    x.loaded0 = r || l;
    sb.push_back(x);
    prev_gray = gray0;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk4("gray0", gray0, got.g0);
    chk4("bin0", bin0, got.b0);
    chk1("wrap0", wrap0, got.w0);
    chk4("gray5", gray5, got.g5);
    chk4("bin5", bin5, got.b5);
    chk1("wrap5", wrap5, got.w5);
    chk4("invariant0", gray0, bin0 ^ (bin0 >> 1));
    chk4("invariant5", gray5, bin5 ^ (bin5 >> 1));
    if (!got.loaded0)
      chk4("bitchange0", 4'($countones(prev_gray ^ gray0)), got.stepped0 ? 4'd1 : 4'd0);
  endtask

  logic [3:0] up_seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    rst = 1'b1; load = 1'b0; load_gray = 4'h0; en = 1'b0; up_dn = 1'b1;

    // Reset, then hold stable.
    drive(1, 0, 4'h0, 0, 1);
    drive(1, 0, 4'h0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 4'h0, 0, 1);
      chk4("rst_hold_gray", gray0, 4'h0);
      chk1("rst_hold_wrap", wrap0, 1'b0);
    end

    // Full up sequence from 0.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 4'h0, 1, 1);
      if (Sat && i == 15) chk4("up_seq_sat", gray0, 4'h8);
      else chk4("up_seq", gray0, up_seq[i]);
      chk1("up_wrap", wrap0, (i == 15));
    end

    // Down count from reset, then a direction flip.
    drive(1, 0, 4'h0, 0, 1);
    drive(0, 0, 4'h0, 1, 0);
    chk1("down_wrap", wrap0, 1'b1);
    chk4("down_first", gray0, Sat ? 4'h0 : 4'h8);
    drive(0, 0, 4'h0, 1, 0);
    drive(0, 0, 4'h0, 1, 0);
    if (!Sat) chk4("down_third", gray0, 4'hB);
    drive(0, 0, 4'h0, 1, 1);
    if (!Sat) chk4("dir_flip", gray0, 4'h9);

    // Load beats enable.
    drive(0, 1, 4'hD, 1, 1);
    chk4("load_gray", gray0, 4'hD);
    chk4("load_bin", bin0, 4'h9);
    chk1("load_wrap", wrap0, 1'b0);
    drive(0, 0, 4'h0, 1, 1);
    chk4("post_load_gray", gray0, 4'hF);
    chk4("post_load_bin", bin0, 4'hA);

    // Reset beats load and enable.
    drive(1, 1, 4'h3, 1, 1);
    chk4("rst_prio_gray5", gray5, 4'h7);
    chk4("rst_prio_bin5", bin5, 4'h5);
    chk1("rst_prio_wrap5", wrap5, 1'b0);

    // Top limit: saturates or wraps depending on build.
    drive(0, 1, 4'h8, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'h0, 1, 1);
      if (Sat) begin
        chk4("sat_hold", gray0, 4'h8);
        chk1("sat_block", wrap0, 1'b1);
      end
    end
    drive(0, 0, 4'h0, 1, 0);
    if (Sat) begin
      chk4("sat_release", gray0, 4'h9);
      chk1("sat_release_wrap", wrap0, 1'b0);
    end

    // Random mix; the model carries the expectations.
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
